// File: rtl/pipe_stage_chain.sv
// Purpose : elastic chain of NUM_STAGES valid/payload registers between pipeline units.
// Latency : NUM_STAGES cycles from input transfer to out_valid on an empty, unstalled chain.
// Backpr. : valid/ready at both ends; in_stall freezes everything; optional bubble collapse.
//
// Ports:
//   Clk, Rst          clock (rising edge) and synchronous active-high reset
//   in_valid/in_data  upstream payload; in_ready says it is taken this cycle
//   out_valid/out_data/out_ready  last-stage payload and downstream acceptance
//   in_stall          global freeze from multi-cycle units
//   in_flush_mask     bit i kills the current occupant of stage i (bit 0 = youngest)
//   out_stage_valid   per-stage valid after the flush mask (hazard/forwarding taps)
//   out_stage_data    stage i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_occupancy     registered count of valid stages
//
// NUM_STAGES must be at least 2.

module pipe_stage_chain #(
  parameter int DATA_WIDTH      = 64,
  parameter int NUM_STAGES      = 4,
  parameter bit BUBBLE_COLLAPSE = 1'b1,
  parameter int CNT_WIDTH       = $clog2(NUM_STAGES + 1)
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  input  logic                             out_ready,
  input  logic                             in_stall,
  input  logic [NUM_STAGES-1:0]            in_flush_mask,
  output logic [NUM_STAGES-1:0]            out_stage_valid,
  output logic [NUM_STAGES*DATA_WIDTH-1:0] out_stage_data,
  output logic [CNT_WIDTH-1:0]             out_occupancy
);

  // Stage state. Element i of the packed data array sits at bits
  // [i*DATA_WIDTH +: DATA_WIDTH], which is exactly the tap layout.
  logic [NUM_STAGES-1:0]                 valid_q, valid_d;
  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]                  occ_q, occ_d;

  // Effective valid: a flushed occupant is treated as already gone.
  logic [NUM_STAGES-1:0] ev;
  // Per-stage advance enable.
  logic [NUM_STAGES-1:0] adv;
  // Last stage can give up its slot this cycle (empty or being drained).
  logic                  drain_ok;

  // What each stage would load when advancing: stage 0 from the input
  // port, stage i from stage i-1.
  logic [NUM_STAGES-1:0]                 up_v;
  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] up_d;

  assign ev       = valid_q & ~in_flush_mask;
  assign drain_ok = ~ev[NUM_STAGES-1] | out_ready;
  assign up_v     = {ev[NUM_STAGES-2:0], in_valid};
  assign up_d     = {data_q[NUM_STAGES-2:0], in_data};

  // ---------------------------------------------------------------------
  // Advance enables
  // ---------------------------------------------------------------------
  // Collapse mode: adv[i] = ~ev[i] | adv[i+1], unrolled as a running OR
  // from the output end so that no vector bit feeds another bit of the
  // same vector (keeps the combinational graph acyclic at signal level).
  // Lockstep mode: every stage follows the last stage's drain condition,
  // so bubbles in the middle of the chain are preserved.
  always_comb begin
    logic acc;
    adv = '0;
    acc = out_ready;
    if (!in_stall) begin
      if (BUBBLE_COLLAPSE) begin
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
          acc    = acc | ~ev[i];
          adv[i] = acc;
        end
      end else begin
        adv = {NUM_STAGES{drain_ok}};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------
  // A stage that does not advance keeps its effective valid, so a flush
  // still removes occupants while the chain is stalled. Data registers
  // only load when a real payload arrives; an empty stage keeps stale
  // data, which is don't-care because its valid is low.
  always_comb begin
    valid_d = ev;
    data_d  = data_q;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (adv[i]) begin
        valid_d[i] = up_v[i];
        if (up_v[i]) begin
          data_d[i] = up_d[i];
        end
      end
    end
  end

  // Occupancy is the popcount of the post-edge valids, so it is exact by
  // construction and can never wrap.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      occ_d = occ_d + CNT_WIDTH'(valid_d[i]);
    end
  end

  // ---------------------------------------------------------------------
  // Registers (reset has priority over stall, flush and handshakes)
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q <= '0;
      data_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // adv is already forced low during a stall; the explicit term keeps the
  // input handshake obviously tied to the freeze.
  assign in_ready        = adv[0] & ~in_stall;
  assign out_valid       = ev[NUM_STAGES-1];
  assign out_data        = data_q[NUM_STAGES-1];
  assign out_stage_valid = ev;
  assign out_stage_data  = data_q;
  assign out_occupancy   = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       in_stall;
  logic [3:0] in_flush_mask;

  // collapse-mode instance (c_) and lockstep-mode instance (l_), same inputs
  logic        c_in_ready, c_out_valid, l_in_ready, l_out_valid;
  logic [7:0]  c_out_data, l_out_data;
  logic [3:0]  c_stage_valid, l_stage_valid;
  logic [31:0] c_stage_data, l_stage_data;
  logic [2:0]  c_occ, l_occ;

  int total = 0;
  int bad   = 0;
  logic [7:0] got[$];

  always #5 Clk = ~Clk;

  pipe_stage_chain #(.DATA_WIDTH(8), .NUM_STAGES(4), .BUBBLE_COLLAPSE(1'b1)) dut_c (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(out_ready),
    .in_stall(in_stall), .in_flush_mask(in_flush_mask),
    .out_stage_valid(c_stage_valid), .out_stage_data(c_stage_data),
    .out_occupancy(c_occ)
  );

  pipe_stage_chain #(.DATA_WIDTH(8), .NUM_STAGES(4), .BUBBLE_COLLAPSE(1'b0)) dut_l (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(l_in_ready),
    .out_valid(l_out_valid), .out_data(l_out_data), .out_ready(out_ready),
    .in_stall(in_stall), .in_flush_mask(in_flush_mask),
    .out_stage_valid(l_stage_valid), .out_stage_data(l_stage_data),
    .out_occupancy(l_occ)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    in_stall = 1'b0; in_flush_mask = 4'b0000;

    // ---- 1. reset then stream ----
    tick;
    check("rst_c_out_valid", c_out_valid, 0);
    check("rst_c_out_data", c_out_data, 0);
    check("rst_c_stage_valid", c_stage_valid, 0);
    check("rst_c_stage_data", c_stage_data, 0);
    check("rst_c_occ", c_occ, 0);
    check("rst_c_in_ready", c_in_ready, 1);
    check("rst_l_occ", l_occ, 0);
    check("rst_l_out_valid", l_out_valid, 0);
    tick;
    Rst = 1'b0; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1; #1;
    check("t1_in_ready", c_in_ready, 1);
    tick; in_data = 8'h22;
    tick; in_data = 8'h33;
    tick; in_valid = 1'b0; #1;
    check("t1_no_early_out", c_out_valid, 0);
    check("t1_occ_peak", c_occ, 3);
    tick;
    check("t1_out_valid_lat4", c_out_valid, 1);
    check("t1_out_11", c_out_data, 8'h11);
    check("t1_l_out_11", l_out_data, 8'h11);
    tick;
    check("t1_out_22", c_out_data, 8'h22);
    tick;
    check("t1_out_33", c_out_data, 8'h33);
    check("t1_occ_1", c_occ, 1);
    tick;
    check("t1_drained_valid", c_out_valid, 0);
    check("t1_drained_occ", c_occ, 0);

    // ---- 2/3. backpressure: collapse vs lockstep ----
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
    tick; in_valid = 1'b0;
    tick;
    tick;
    tick;
    check("t3_l_stage3_a1", l_stage_valid, 4'b1000);
    in_valid = 1'b1; in_data = 8'hA2; #1;
    check("t3_l_in_ready_0", l_in_ready, 0);
    check("t2_c_in_ready_1", c_in_ready, 1);
    tick; in_valid = 1'b0;
    tick;
    tick;
    tick;
    check("t2_c_occ_2", c_occ, 2);
    check("t2_c_stage_valid", c_stage_valid, 4'b1100);
    check("t2_c_stage3_a1", c_stage_data[31:24], 8'hA1);
    check("t2_c_stage2_a2", c_stage_data[23:16], 8'hA2);
    check("t2_c_in_ready_2held", c_in_ready, 1);
    check("t3_l_occ_1", l_occ, 1);
    check("t3_l_in_ready_frozen", l_in_ready, 0);
    in_valid = 1'b1; in_data = 8'hB1;
    tick; in_data = 8'hB2; #1;
    check("t2_c_occ_3", c_occ, 3);
    check("t2_c_in_ready_3held", c_in_ready, 1);
    tick; in_valid = 1'b0; #1;
    check("t2_c_occ_4", c_occ, 4);
    check("t2_c_in_ready_full", c_in_ready, 0);
    check("t3_l_occ_still_1", l_occ, 1);
    out_ready = 1'b1; #1;
    check("t2_c_drain_a1", c_out_data, 8'hA1);
    check("t2_c_full_in_ready", c_in_ready, 1);
    tick;
    check("t2_c_drain_a2", c_out_data, 8'hA2);
    check("t3_l_empty", l_occ, 0);
    tick; tick; tick; tick;
    check("t2_c_empty", c_occ, 0);

    // ---- 4. flush ----
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_data = 8'(k);
      tick;
    end
    check("t4_c_full_taps", c_stage_data, 32'h01020304);
    check("t4_c_full_occ", c_occ, 4);
    check("t4_l_full_taps", l_stage_data, 32'h01020304);
    in_flush_mask = 4'b0011; in_data = 8'h05; out_ready = 1'b1; #1;
    check("t4_ev_masked", c_stage_valid, 4'b1100);
    check("t4_in_ready", c_in_ready, 1);
    got.delete();
    for (int k = 0; k < 7; k++) begin
      if (c_out_valid && out_ready && !in_stall) got.push_back(c_out_data);
      tick;
      if (k == 0) begin
        check("t4_occ_drop2", c_occ, 2);
        in_flush_mask = 4'b0000; in_valid = 1'b0;
      end
      #1;
    end
    check("t4_delivered_cnt", got.size(), 3);
    if (got.size() == 3) begin
      check("t4_deliv0", got[0], 8'h01);
      check("t4_deliv1", got[1], 8'h02);
      check("t4_deliv2", got[2], 8'h05);
    end
    check("t4_l_empty", l_occ, 0);

    // ---- 5. stall ----
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_data = 8'(k);
      tick;
    end
    in_stall = 1'b1; out_ready = 1'b1; in_data = 8'h66; #1;
    for (int k = 0; k < 5; k++) begin
      check("t5_c_in_ready_0", c_in_ready, 0);
      check("t5_l_in_ready_0", l_in_ready, 0);
      tick;
      check("t5_c_taps_frozen", c_stage_data, 32'h01020304);
      check("t5_c_occ_4", c_occ, 4);
    end
    in_stall = 1'b0; in_valid = 1'b0; #1;
    check("t5_release_valid", c_out_valid, 1);
    check("t5_release_01", c_out_data, 8'h01);
    check("t5_release_in_ready", c_in_ready, 1);
    tick;
    check("t5_after_occ", c_occ, 3);
    check("t5_after_02", c_out_data, 8'h02);

    // flush of the last stage beats the output transfer
    in_flush_mask = 4'b1000; #1;
    check("fw_out_valid_0", c_out_valid, 0);
    tick; in_flush_mask = 4'b0000; #1;
    check("fw_next_03", c_out_data, 8'h03);
    check("fw_occ_2", c_occ, 2);
    check("fw_stage_valid", c_stage_valid, 4'b1100);

    // ---- 6. reset mid-operation ----
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    tick; in_data = 8'h88;
    tick;
    check("t6_c_full", c_occ, 4);
    check("t6_l_frozen_occ", l_occ, 2);
    Rst = 1'b1; in_data = 8'h99;
    tick;
    check("t6_rst_c_valid", c_stage_valid, 0);
    check("t6_rst_c_occ", c_occ, 0);
    check("t6_rst_c_out_valid", c_out_valid, 0);
    check("t6_rst_c_data", c_stage_data, 0);
    check("t6_rst_l_occ", l_occ, 0);
    Rst = 1'b0; in_valid = 1'b0;
    tick;
    check("t6_no_capture_valid", c_stage_valid, 0);
    check("t6_no_capture_occ", c_occ, 0);
    check("t6_l_no_capture", l_stage_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised elastic pipeline-register chain that replaces the fixed-width, lockstep stage buffers between the fetch, decode, execute, memory and writeback stages.
- Each stage carries a valid bit alongside its payload.
- Provides a valid/ready handshake at both ends, a global stall from multi-cycle units (FPU), per-stage flush for branch mispredicts, and optional bubble collapse.
- Per-stage taps are exported for the forwarding and hazard logic.

Parameters:
DATA_WIDTH, 64, payload bits per stage
NUM_STAGES, 4, number of register stages (≥2)
BUBBLE_COLLAPSE, 1, 1 = a stage advances whenever its successor is empty or advancing; 0 = lockstep, all stages advance only when the last stage can drain
CNT_WIDTH, $clog2(NUM_STAGES+1), occupancy counter width

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream payload valid
in_data  input  DATA_WIDTH  upstream payload
in_ready  output  1  chain accepts in_data this cycle
out_valid  output  1  last-stage payload valid
out_data  output  DATA_WIDTH  last-stage payload
out_ready  input  1  downstream accepts out_data
in_stall  input  1  global freeze (multi-cycle unit busy)
in_flush_mask  input  NUM_STAGES  bit i kills current occupant of stage i (bit 0 = youngest)
out_stage_valid  output  NUM_STAGES  effective valid per stage (after flush mask)
out_stage_data  output  NUM_STAGES*DATA_WIDTH  stage i payload at bits [i*DATA_WIDTH +: DATA_WIDTH]
out_occupancy  output  CNT_WIDTH  registered count of valid stages

Behaviour:
- One clock (Clk); reset (Rst) is synchronous and active-high.
- Reset: all stage valid bits, all stage data, and out_occupancy go to 0. Therefore out_valid=0, out_data=0, out_stage_valid=0, in_ready=1 (if in_stall=0). Rst has priority over every other input.
- Effective valid: ev[i] = valid[i] & ~in_flush_mask[i]. All advance, handshake and tap logic uses ev. out_valid = ev[NUM_STAGES-1], combinational.
- Advance (BUBBLE_COLLAPSE=1):
  - adv[N-1] = ~ev[N-1] | out_ready
  - adv[i] = ~ev[i] | adv[i+1]
- Advance (BUBBLE_COLLAPSE=0): every adv[i] = ~ev[N-1] | out_ready.
- Stall: in_stall=1 forces all adv=0 and in_ready=0. Data and valids freeze. Flush still clears valids during stall.
- Stage update on a clock edge:
  - if adv[i]: valid[i] <= ev[i-1] and data[i] <= data[i-1].
  - Stage 0 takes in_valid / in_data.
  - Otherwise valid[i] <= ev[i] and data holds.
- Data load gating: a data register loads only when the incoming valid is 1 (power). Data of an invalid stage holds its last value and is don't-care.
- in_ready = adv[0] & ~in_stall. An input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready & ~in_stall.
- Flushed entries never propagate and never appear on out_valid. The input accepted in the same cycle is unaffected by in_flush_mask.
- Latency: NUM_STAGES cycles from input transfer to out_valid on an empty, unstalled chain. Throughput is 1 transfer/cycle with out_ready held at 1.
- Full chain with out_ready=1: accept and drain in the same cycle, so in_ready stays 1.
- BUBBLE_COLLAPSE=0 with out_ready=0 and ev[N-1]=1: whole chain frozen, in_ready=0, even if earlier stages are empty.
- out_occupancy is registered and equals popcount(valid) after the edge. Range 0..NUM_STAGES, never wraps.
- Flush and output transfer on the same last stage: flush wins, no transfer.

Test Plan (NUM_STAGES=4, DATA_WIDTH=8):
1. Reset then stream: Rst=1 for 2 cycles, then in_valid=1 with data 0x11, 0x22, 0x33, out_ready=1 → out_valid rises exactly 4 cycles after 0x11 is accepted. Outputs 0x11, 0x22, 0x33 appear on consecutive cycles. out_occupancy peaks at 3. All outputs are 0 during reset.
2. Backpressure collapse (BUBBLE_COLLAPSE=1): feed 0xA1 then bubble then 0xA2, with out_ready=0 → the bubble is squeezed out. out_occupancy=2 with 0xA1 in stage 3 and 0xA2 in stage 2. in_ready stays 1 until 4 entries are held, then 0.
3. Lockstep mode (BUBBLE_COLLAPSE=0): same stimulus → in_ready=0 as soon as stage 3 holds 0xA1 and out_ready=0. Bubble is preserved, out_occupancy=1.
4. Flush: chain holds 0x01..0x04 (stage 3 = 0x01). Pulse in_flush_mask=4'b0011 for one cycle while accepting 0x05 → only 0x01, 0x02 and 0x05 are delivered. out_occupancy drops by 2.
5. Stall: full chain, in_stall=1 for 5 cycles with out_ready=1 → no output transfer, in_ready=0, taps unchanged. After release, 0x01 is delivered on the first cycle.
6. Reset mid-operation: Rst=1 for one cycle with a full chain and in_valid=1 → next cycle all valids are 0, out_occupancy=0, and the input is not captured.
